pcie_req_sched: RTL and testbench
=================================

# pcie_req_sched

Scheduler between NUM_REQ local requesters and the single PCIe request/completion channel pair of the endpoint link interface. It arbitrates round-robin for the request channel and allocates a transaction tag to every memory-read (non-posted) TLP. It tracks outstanding reads and routes each returning completion TLP back to the requester that issued it. It sits between host-side traffic agents/DMA engines and the `req_*`/`cpl_*` link signals.

## Interface
- NUM_REQ, 4: number of requester ports (2..8)
- NUM_TAGS, 16: outstanding non-posted tags (power of 2, ≤256)
- TLP_W, 128: packed TLP width
- PCIE_CLK  in  1  clock
- PCIE_RSTn  in  1  reset; synchronous, active-low
- rq_valid  in  NUM_REQ  per-requester request valid
- rq_ready  out  NUM_REQ  per-requester request accept
- rq_tlp  in  NUM_REQ*TLP_W  per-requester TLP; requester i occupies bits [i*TLP_W +: TLP_W]
- rc_valid  out  NUM_REQ  completion valid to owner
- rc_ready  in  NUM_REQ  per-requester completion accept
- rc_tlp  out  TLP_W  completion TLP, broadcast to all requesters
- req_valid  out  1  link request valid
- req_ready  in  1  link request accept
- req_tlp  out  TLP_W  link request TLP
- cpl_valid  in  1  link completion valid
- cpl_ready  out  1  link completion accept
- cpl_tlp  in  TLP_W  link completion TLP
- tags_free  out  $clog2(NUM_TAGS)+1  count of free tags
- err_unexp_cpl  out  1  one-cycle pulse on a completion with a non-outstanding tag

## Operation
- TLP fields: bit 126 = 1 means write (posted); bit 126 = 0 means read (non-posted). Tag occupies [71:64] in both request and completion TLPs.
- Eligibility: write always eligible. Read eligible only when tags_free > 0.
- Arbitration: round-robin over eligible requesters, starting at pointer `rr`. After a grant to requester g, `rr` becomes (g+1) mod NUM_REQ. `rr` does not change when no grant occurs.
- Output stage FSM:
  - EMPTY: a grant loads the output register, then go to FULL.
  - FULL: if req_ready is high, then load a new grant (stay FULL) or, with no grant, go to EMPTY. If req_ready is low, hold.
- A grant happens only in a cycle where the output register is EMPTY or is being drained (req_valid && req_ready). rq_ready[g] is high in exactly that cycle.
- Read grant: allocate the lowest-numbered free tag t and overwrite req_tlp[71:64] with t (upper bits zero). Record owner[t]=g and valid[t]=1. Any requester-supplied tag is ignored. Writes pass through unmodified.
- Completion routing: when cpl_valid is high and the tag in cpl_tlp is outstanding (owner o):
  - rc_valid[o]=1 and cpl_ready=rc_ready[o], combinationally.
  - rc_tlp=cpl_tlp.
  - On handshake, clear valid[t]. One completion per read.
- Unexpected completion (tag not outstanding, or tag ≥ NUM_TAGS): cpl_ready=1, all rc_valid=0, and err_unexp_cpl pulses in the following cycle.
- tags_free = NUM_TAGS − popcount(valid), registered.

## Timing
- Reset values: req_valid=0, req_tlp=0, rq_ready=0, rc_valid=0, cpl_ready=0, err_unexp_cpl=0, tags_free=NUM_TAGS, rr=0, all valid[]=0.
- Latency: rq_valid at cycle T with EMPTY stage gives req_valid=1 at T+1.
- Throughput: one TLP per cycle while req_ready stays high.
- req_valid/req_tlp stay stable until accepted. Requesters hold rq_tlp stable while rq_valid && !rq_ready.
- A tag freed by a completion in cycle T is allocatable from T+1. There is no same-cycle bypass; allocation and freeing of different tags in one cycle are both honoured.
- Last tag allocated in cycle T: reads are ineligible from T+1 until a free occurs.
- Synchronous reset asserted mid-operation clears all state on that edge. In-flight tags are forgotten, and later completions for them count as unexpected.

## Structure
- Package pcie_sched_pkg holds: TLP_W, TAG_LSB=64, TAG_W=8, TYPE_BIT=126, and functions is_read(tlp) and get_tag(tlp).
- Sub-module pcie_tag_alloc holds the free vector, find-first-free logic, the owner table, alloc/free ports and the tags_free counter.
- Arbiter, output register and completion mux live in the top module.

## Test plan
- Reset then idle: all outputs at reset values; tags_free=16.
- Requesters 0..3 each issue one write together, req_ready=1: req_tlp order 0,1,2,3 on consecutive cycles; first at T+1; tags unmodified.
- 16 reads from requester 1, no completions: tags 0..15 assigned in order; 17th read stalls with rq_ready=0 and tags_free=0. A concurrent write from requester 2 still passes.
- Completion tag 5 (owner 1) with rc_ready[1]=0 for 3 cycles: cpl_ready=0 and rc_valid[1] held. Handshake on release, then the stalled read receives tag 5 on the next cycle.
- Completion tag 9 with no outstanding read: cpl_ready=1, rc_valid=0, err_unexp_cpl=1 one cycle later.
- req_ready=0 for 4 cycles with requests pending: req_tlp is stable and no rq_ready. Reset mid-stall: tables cleared and tags_free=16.

Source files
------------

// File: rtl/pcie_sched_pkg.sv
// pcie_sched_pkg: TLP field layout, output-stage states and field helpers for the PCIe request scheduler
package pcie_sched_pkg;
    localparam int TLP_W    = 128;
    localparam int TAG_LSB  = 64;
    localparam int TAG_W    = 8;
    localparam int TYPE_BIT = 126;
    typedef enum logic {S_EMPTY, S_FULL} out_state_e;
    function automatic logic is_read(input logic [TLP_W-1:0] tlp);
        return !tlp[TYPE_BIT];
    endfunction
    function automatic logic [TAG_W-1:0] get_tag(input logic [TLP_W-1:0] tlp);
        return tlp[TAG_LSB +: TAG_W];
    endfunction
endpackage

// File: rtl/pcie_tag_alloc.sv
// pcie_tag_alloc: outstanding-tag vector, lowest-free allocation, owner table and registered free-tag count
module pcie_tag_alloc
    import pcie_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_TAGS = 16,
    localparam int IW = $clog2(NUM_TAGS),
    localparam int RW = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc,
    input  logic [RW-1:0]    alloc_owner,
    output logic [IW-1:0]    alloc_tag,
    input  logic             free_en,
    input  logic [IW-1:0]    free_tag,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_hit,
    output logic [RW-1:0]    lookup_owner,
    output logic [IW:0]      tags_free
);
    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [RW-1:0]       owner_q [NUM_TAGS];
    logic [IW:0]         busy_d;
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--)
            if (!valid_q[i]) alloc_tag = IW'(i);
    end
    always_comb begin
        valid_d = valid_q;
        if (alloc) valid_d[alloc_tag] = 1'b1;
        if (free_en) valid_d[free_tag] = 1'b0;
    end
    always_comb begin
        busy_d = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            busy_d = busy_d + (IW+1)'(valid_d[i]);
    end
    assign lookup_hit   = ({1'b0, lookup_tag} < (TAG_W+1)'(NUM_TAGS)) && valid_q[lookup_tag[IW-1:0]];
    assign lookup_owner = owner_q[lookup_tag[IW-1:0]];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= '0;
            tags_free <= (IW+1)'(NUM_TAGS);
        end else begin
            valid_q   <= valid_d;
            tags_free <= (IW+1)'(NUM_TAGS) - busy_d;
            if (alloc) owner_q[alloc_tag] <= alloc_owner;
        end
    end
endmodule

// File: rtl/pcie_req_sched.sv
// pcie_req_sched: round-robin request arbiter with read-tag allocation and completion routing for one PCIe link
module pcie_req_sched
    import pcie_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_TAGS = 16,
    parameter int TLP_W    = 128,
    localparam int RW = $clog2(NUM_REQ),
    localparam int IW = $clog2(NUM_TAGS)
) (
    input  logic                     PCIE_CLK,
    input  logic                     PCIE_RSTn,
    input  logic [NUM_REQ-1:0]       rq_valid,
    output logic [NUM_REQ-1:0]       rq_ready,
    input  logic [NUM_REQ*TLP_W-1:0] rq_tlp,
    output logic [NUM_REQ-1:0]       rc_valid,
    input  logic [NUM_REQ-1:0]       rc_ready,
    output logic [TLP_W-1:0]         rc_tlp,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [TLP_W-1:0]         req_tlp,
    input  logic                     cpl_valid,
    output logic                     cpl_ready,
    input  logic [TLP_W-1:0]         cpl_tlp,
    output logic [IW:0]              tags_free,
    output logic                     err_unexp_cpl
);
    out_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] elig;
    logic [RW-1:0]      rr_q, gnt_idx, owner;
    logic               gnt_any, grant, alloc, hit, free_en;
    logic [TLP_W-1:0]   gnt_tlp, load_tlp;
    logic [IW-1:0]      alloc_tag;
    logic [TAG_W-1:0]   cpl_tag;
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = rq_valid[i] && (!is_read(rq_tlp[i*TLP_W +: TLP_W]) || tags_free != '0);
    end
    // scan from the highest offset down so the eligible requester closest after rr wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = rr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (elig[(int'(rr_q) + k) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = RW'((int'(rr_q) + k) % NUM_REQ);
            end
    end
    assign req_valid = state_q == S_FULL;
    assign grant     = gnt_any && (!req_valid || req_ready) && PCIE_RSTn;
    assign rq_ready  = grant ? NUM_REQ'(1) << gnt_idx : '0;
    assign gnt_tlp   = rq_tlp[gnt_idx*TLP_W +: TLP_W];
    assign alloc     = grant && is_read(gnt_tlp);
    assign load_tlp  = is_read(gnt_tlp) ? {gnt_tlp[TLP_W-1:TAG_LSB+TAG_W], TAG_W'(alloc_tag), gnt_tlp[TAG_LSB-1:0]} : gnt_tlp;
    always_comb begin
        state_d = state_q;
        state_d = (state_q == S_FULL && !req_ready) || grant ? S_FULL : S_EMPTY;
    end
    assign cpl_tag   = get_tag(cpl_tlp);
    assign rc_tlp    = cpl_tlp;
    assign rc_valid  = cpl_valid && hit && PCIE_RSTn ? NUM_REQ'(1) << owner : '0;
    assign cpl_ready = cpl_valid && PCIE_RSTn && (!hit || rc_ready[owner]);
    assign free_en   = cpl_valid && hit && rc_ready[owner];
    pcie_tag_alloc #(.NUM_REQ(NUM_REQ), .NUM_TAGS(NUM_TAGS)) u_tags (
        .clk(PCIE_CLK),
        .rst_n(PCIE_RSTn),
        .alloc(alloc),
        .alloc_owner(gnt_idx),
        .alloc_tag(alloc_tag),
        .free_en(free_en),
        .free_tag(cpl_tag[IW-1:0]),
        .lookup_tag(cpl_tag),
        .lookup_hit(hit),
        .lookup_owner(owner),
        .tags_free(tags_free)
    );
    always_ff @(posedge PCIE_CLK) begin
        if (!PCIE_RSTn) begin
            state_q       <= S_EMPTY;
            req_tlp       <= '0;
            rr_q          <= '0;
            err_unexp_cpl <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_unexp_cpl <= cpl_valid && !hit;
            if (grant) begin
                req_tlp <= load_tlp;
                rr_q    <= gnt_idx == RW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pcie_req_sched.sv
// tb_pcie_req_sched: scoreboard bench with a tag/round-robin reference model and randomized traffic
module tb_pcie_req_sched;
    localparam int N = 4;
    localparam int T = 16;
    localparam int W = 128;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] rq_valid = '0, rq_ready, rc_valid, rc_ready = '0;
    logic [N*W-1:0] rq_tlp = '0;
    logic [W-1:0] rc_tlp, req_tlp, cpl_tlp = '0;
    logic req_valid, req_ready = 1'b0, cpl_valid = 1'b0, cpl_ready, err;
    logic [4:0] tags_free;
    always #5 clk = ~clk;
    pcie_req_sched #(.NUM_REQ(N), .NUM_TAGS(T), .TLP_W(W)) dut (
        .PCIE_CLK(clk), .PCIE_RSTn(rst_n),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_tlp(rq_tlp),
        .rc_valid(rc_valid), .rc_ready(rc_ready), .rc_tlp(rc_tlp),
        .req_valid(req_valid), .req_ready(req_ready), .req_tlp(req_tlp),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tlp(cpl_tlp),
        .tags_free(tags_free), .err_unexp_cpl(err)
    );
    int checks = 0, errors = 0;
    logic [W-1:0] req_q[$];
    bit outm[T];
    int own[T];
    int rr_m = 0;
    bit err_exp = 0, cpl_hs = 0, cpl_pend = 0;
    bit acc[N], pend[N];
    logic [W-1:0] ptlp[N];
    int p_gen = 0, p_rdy = 0, p_rc = 0, cpl_mode = 0, cpl_force = 0;
    int rd_pct[N];
    bit [N-1:0] gen_mask = '0;
    int m_nout, m_g, m_j, m_tag, m_a;
    bit m_hit, m_hs;
    logic [W-1:0] m_t;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) pend[i] = 0;
            acc[i] = 0;
            if (!pend[i] && gen_mask[i] && int'($urandom_range(99)) < p_gen) begin
                pend[i] = 1;
                ptlp[i] = {$urandom, $urandom, $urandom, $urandom};
                ptlp[i][126] = int'($urandom_range(99)) >= rd_pct[i];
            end
            rq_valid[i] = pend[i];
            rq_tlp[i*W +: W] = ptlp[i];
            rc_ready[i] = int'($urandom_range(99)) < p_rc;
        end
        if (cpl_hs) cpl_pend = 0;
        cpl_hs = 0;
        if (!cpl_pend && cpl_mode != 0) begin
            int tag;
            int list[$];
            tag = -1;
            if (cpl_mode == 2) begin
                tag = cpl_force;
                cpl_mode = 0;
            end else if ($urandom_range(99) < 40) begin
                for (int t = 0; t < T; t++) if (outm[t]) list.push_back(t);
                tag = (list.size() > 0 && $urandom_range(9) < 8) ? list[$urandom_range(list.size() - 1)] : int'($urandom_range(255));
            end
            if (tag >= 0) begin
                cpl_pend = 1;
                cpl_tlp = {$urandom, $urandom, $urandom, $urandom};
                cpl_tlp[71:64] = 8'(tag);
            end
        end
        cpl_valid = cpl_pend;
        req_ready = int'($urandom_range(99)) < p_rdy;
    endtask

    task automatic run(input int n, input bit rst = 0);
        repeat (n) begin
            step();
            rst_n = !rst;
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            chk("rst_rq_ready", rq_ready, 0);
            chk("rst_rc_valid", rc_valid, 0);
            chk("rst_cpl_ready", cpl_ready, 0);
            req_q.delete();
            for (int t = 0; t < T; t++) outm[t] = 0;
            for (int i = 0; i < N; i++) acc[i] = 0;
            rr_m = 0;
            err_exp = 0;
            cpl_hs = 0;
        end else begin
            m_nout = 0;
            for (int t = 0; t < T; t++) m_nout += int'(outm[t]);
            chk("tags_free", tags_free, T - m_nout);
            chk("err_unexp_cpl", err, err_exp);
            chk("req_valid", req_valid, req_q.size() != 0);
            m_g = -1;
            if (req_q.size() == 0 || req_ready)
                for (int k = 0; k < N && m_g < 0; k++) begin
                    m_j = (rr_m + k) % N;
                    if (rq_valid[m_j] && (rq_tlp[m_j*W + 126] || m_nout < T)) m_g = m_j;
                end
            chk("rq_ready", rq_ready, m_g < 0 ? 0 : 1 << m_g);
            m_hit = 0;
            m_hs = 0;
            err_exp = 0;
            m_tag = 0;
            if (cpl_valid) begin
                m_tag = int'(cpl_tlp[71:64]);
                m_hit = m_tag < T && outm[m_tag];
                if (m_hit) begin
                    chk("rc_valid_owner", rc_valid, 1 << own[m_tag]);
                    chk("cpl_ready_owner", cpl_ready, rc_ready[own[m_tag]]);
                    chk("rc_tlp", rc_tlp, cpl_tlp);
                    m_hs = rc_ready[own[m_tag]];
                end else begin
                    chk("rc_valid_unexp", rc_valid, 0);
                    chk("cpl_ready_unexp", cpl_ready, 1);
                    m_hs = 1;
                    err_exp = 1;
                end
            end else begin
                chk("rc_valid_idle", rc_valid, 0);
                chk("cpl_ready_idle", cpl_ready, 0);
            end
            cpl_hs = m_hs;
            if (m_g >= 0) begin
                acc[m_g] = 1;
                m_t = rq_tlp[m_g*W +: W];
                if (!m_t[126]) begin
                    m_a = 0;
                    while (outm[m_a]) m_a++;
                    m_t[71:64] = 8'(m_a);
                    outm[m_a] = 1;
                    own[m_a] = m_g;
                end
                req_q.push_back(m_t);
                rr_m = (m_g + 1) % N;
            end
            if (m_hit && m_hs) outm[m_tag] = 0;
        end
    end

    always @(negedge clk) begin
        #3;
        if (rst_n && req_valid) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_spurious: got %0h expected no request", req_tlp);
            end else begin
                chk("req_tlp", req_tlp, req_q[0]);
                if (req_ready) void'(req_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rd_pct[i] = 0;
            pend[i] = 0;
            acc[i] = 0;
            ptlp[i] = '0;
        end
        run(3, 1);
        run(3);
        #4 chk("idle_tags_free", tags_free, 16);
        chk("idle_req_valid", req_valid, 0);
        gen_mask = 4'hF;
        p_gen = 100;
        p_rdy = 100;
        p_rc = 100;
        run(1);
        gen_mask = 0;
        run(6);
        gen_mask = 4'b0010;
        rd_pct[1] = 100;
        run(18);
        gen_mask = 4'b0110;
        rd_pct[2] = 0;
        run(4);
        #4 chk("exhausted_tags_free", tags_free, 0);
        chk("exhausted_rq_ready1", rq_ready[1], 0);
        gen_mask = 4'b0010;
        p_rc = 0;
        cpl_mode = 2;
        cpl_force = 5;
        run(3);
        #4 chk("cpl5_rc_valid", rc_valid, 4'b0010);
        chk("cpl5_cpl_ready", cpl_ready, 0);
        p_rc = 100;
        run(2);
        #4 chk("regrant_tag5", rq_ready, 4'b0010);
        gen_mask = 4'hF;
        for (int i = 0; i < N; i++) rd_pct[i] = 50;
        p_rdy = 0;
        run(6);
        #4 chk("stall_rq_ready", rq_ready, 0);
        chk("stall_req_valid", req_valid, 1);
        gen_mask = 0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        run(1, 1);
        run(1);
        #4 chk("post_rst_tags_free", tags_free, 16);
        chk("post_rst_req_valid", req_valid, 0);
        cpl_mode = 2;
        cpl_force = 9;
        run(1);
        #4 chk("unexp9_cpl_ready", cpl_ready, 1);
        chk("unexp9_rc_valid", rc_valid, 0);
        run(1);
        #4 chk("unexp9_err", err, 1);
        gen_mask = 4'hF;
        p_gen = 50;
        p_rdy = 70;
        p_rc = 70;
        cpl_mode = 1;
        run(3000);
        run(1, 1);
        run(1500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
